// File: rtl/cep_encoder_tx.sv
// CEP packet encoder: packs header fields and payload words into one wide packet
// and queues it for a ready/valid consumer. Optional macro: CEP_ENCODER_TX_STATS_EN.
`ifndef CEP_DEFINES_VH
`define CEP_DEFINES_VH
`define CEP_WORD_WIDTH         64
`define CEP_DATA_WIDTH         512
`define CEP_IS_REQ_WIDTH       1
`define CEP_LAST_SUBLINE_WIDTH 1
`define CEP_SUBLINE_ID_WIDTH   2
`define CEP_MESI_WIDTH         2
`define CEP_MSHRID_WIDTH       8
`define CEP_MSG_TYPE_WIDTH     5
`define CEP_LENGTH_WIDTH       3
`define CEP_DATA_SIZE_WIDTH    3
`define CEP_CACHE_TYPE_WIDTH   1
`define CEP_ADDR_WIDTH         32
`define CEP_SRC_CHIPID_WIDTH   6
`define CEP_IS_REQ             0
`define CEP_LAST_SUBLINE       1
`define CEP_SUBLINE_ID         3:2
`define CEP_MESI               5:4
`define CEP_MSHRID             13:6
`define CEP_MSG_TYPE           18:14
`define CEP_LENGTH             21:19
`define CEP_DATA_SIZE          24:22
`define CEP_CACHE_TYPE         25
`define CEP_ADDR               57:26
`define CEP_SRC_CHIPID         63:58
`endif

module cep_encoder_tx #(
  parameter int DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_val,
  output logic                                in_rdy,
  input  logic [`CEP_IS_REQ_WIDTH-1:0]        is_request,
  input  logic [`CEP_LAST_SUBLINE_WIDTH-1:0]  last_subline,
  input  logic [`CEP_SUBLINE_ID_WIDTH-1:0]    subline_id,
  input  logic [`CEP_MESI_WIDTH-1:0]          mesi,
  input  logic [`CEP_MSHRID_WIDTH-1:0]        mshrid,
  input  logic [`CEP_MSG_TYPE_WIDTH-1:0]      msg_type,
  input  logic [`CEP_LENGTH_WIDTH-1:0]        length,
  input  logic [`CEP_DATA_SIZE_WIDTH-1:0]     data_size,
  input  logic [`CEP_CACHE_TYPE_WIDTH-1:0]    cache_type,
  input  logic [`CEP_ADDR_WIDTH-1:0]          addr,
  input  logic [`CEP_SRC_CHIPID_WIDTH-1:0]    src_chipid,
  input  logic [7*`CEP_WORD_WIDTH-1:0]        data,
  output logic                                out_val,
  input  logic                                out_rdy,
  output logic [`CEP_DATA_WIDTH-1:0]          out_pkg,
  output logic [15:0]                         stat_req_cnt,
  output logic [15:0]                         stat_resp_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = `CEP_WORD_WIDTH;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OCC_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [`CEP_DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]              wr_ptr_r;
  logic [AW-1:0]              rd_ptr_r;
  logic [AW:0]                occ_r;
  logic                       rdy_en_r;
  logic [`CEP_DATA_WIDTH-1:0] pkg_s;
  logic                       push_s;
  logic                       pop_s;

  // rdy_en_r keeps in_rdy low during reset and for the edge that follows it
  assign in_rdy  = rdy_en_r && (occ_r < DEPTH_C);
  assign out_val = (occ_r != {(AW+1){1'b0}});
  assign push_s  = in_val && in_rdy;
  assign pop_s   = out_val && out_rdy;
  assign out_pkg = mem_r[rd_ptr_r];

  // Build the packet image from header fields and payload words
  always_comb begin
    pkg_s = {`CEP_DATA_WIDTH{1'b0}};
    pkg_s[`CEP_IS_REQ]       = is_request;
    pkg_s[`CEP_LAST_SUBLINE] = last_subline;
    pkg_s[`CEP_SUBLINE_ID]   = subline_id;
    pkg_s[`CEP_MESI]         = mesi;
    pkg_s[`CEP_MSHRID]       = mshrid;
    pkg_s[`CEP_MSG_TYPE]     = msg_type;
    pkg_s[`CEP_LENGTH]       = length;
    pkg_s[`CEP_DATA_SIZE]    = data_size;
    pkg_s[`CEP_CACHE_TYPE]   = cache_type;
    pkg_s[`CEP_ADDR]         = addr;
    pkg_s[`CEP_SRC_CHIPID]   = src_chipid;
    if (is_request == 1'b1) begin
      // requests carry only five payload words, starting at slot 3
      for (int k = 0; k < 5; k++) begin
        pkg_s[(k+3)*WW +: WW] = data[k*WW +: WW];
      end
    end else begin
      for (int k = 0; k < 7; k++) begin
        pkg_s[(k+1)*WW +: WW] = data[k*WW +: WW];
      end
    end
  end

  // Queue storage; entries are not reset, stale contents are never visible
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= pkg_s;
    end
  end

  // Pointers, occupancy and ready enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      occ_r    <= {(AW+1){1'b0}};
      rdy_en_r <= 1'b0;
    end else begin
      rdy_en_r <= 1'b1;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_ONE;
        2'b01:   occ_r <= occ_r - OCC_ONE;
        default: occ_r <= occ_r;
      endcase
    end
  end

`ifdef CEP_ENCODER_TX_STATS_EN
  logic [15:0] req_cnt_r;
  logic [15:0] resp_cnt_r;

  // Saturating hand-off counters split by the packet's request bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_cnt_r  <= 16'h0000;
      resp_cnt_r <= 16'h0000;
    end else if (pop_s) begin
      if (out_pkg[`CEP_IS_REQ] == 1'b1) begin
        if (req_cnt_r != 16'hFFFF) begin
          req_cnt_r <= req_cnt_r + 16'h0001;
        end
      end else begin
        if (resp_cnt_r != 16'hFFFF) begin
          resp_cnt_r <= resp_cnt_r + 16'h0001;
        end
      end
    end
  end

  assign stat_req_cnt  = req_cnt_r;
  assign stat_resp_cnt = resp_cnt_r;
`else
  assign stat_req_cnt  = 16'h0000;
  assign stat_resp_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cep_encoder_tx.sv
// Randomized self-checking bench for cep_encoder_tx with a queue-based reference
// model; expected packets are built by concatenating fields in header order.
`ifndef CEP_DEFINES_VH
`define CEP_DEFINES_VH
`define CEP_WORD_WIDTH         64
`define CEP_DATA_WIDTH         512
`define CEP_IS_REQ_WIDTH       1
`define CEP_LAST_SUBLINE_WIDTH 1
`define CEP_SUBLINE_ID_WIDTH   2
`define CEP_MESI_WIDTH         2
`define CEP_MSHRID_WIDTH       8
`define CEP_MSG_TYPE_WIDTH     5
`define CEP_LENGTH_WIDTH       3
`define CEP_DATA_SIZE_WIDTH    3
`define CEP_CACHE_TYPE_WIDTH   1
`define CEP_ADDR_WIDTH         32
`define CEP_SRC_CHIPID_WIDTH   6
`define CEP_IS_REQ             0
`define CEP_LAST_SUBLINE       1
`define CEP_SUBLINE_ID         3:2
`define CEP_MESI               5:4
`define CEP_MSHRID             13:6
`define CEP_MSG_TYPE           18:14
`define CEP_LENGTH             21:19
`define CEP_DATA_SIZE          24:22
`define CEP_CACHE_TYPE         25
`define CEP_ADDR               57:26
`define CEP_SRC_CHIPID         63:58
`endif

module tb_cep_encoder_tx;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic         is_req;
    logic         last;
    logic [1:0]   sub;
    logic [1:0]   mesi;
    logic [7:0]   mshrid;
    logic [4:0]   msg;
    logic [2:0]   len;
    logic [2:0]   dsz;
    logic         ct;
    logic [31:0]  addr;
    logic [5:0]   chip;
    logic [447:0] data;
  } pkt_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_val = 1'b0;
  logic         in_rdy;
  logic [0:0]   is_request = '0;
  logic [0:0]   last_subline = '0;
  logic [1:0]   subline_id = '0;
  logic [1:0]   mesi = '0;
  logic [7:0]   mshrid = '0;
  logic [4:0]   msg_type = '0;
  logic [2:0]   length = '0;
  logic [2:0]   data_size = '0;
  logic [0:0]   cache_type = '0;
  logic [31:0]  addr = '0;
  logic [5:0]   src_chipid = '0;
  logic [447:0] data = '0;
  logic         out_val;
  logic         out_rdy = 1'b0;
  logic [511:0] out_pkg;
  logic [15:0]  stat_req_cnt;
  logic [15:0]  stat_resp_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  cep_encoder_tx #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy),
    .is_request(is_request), .last_subline(last_subline), .subline_id(subline_id),
    .mesi(mesi), .mshrid(mshrid), .msg_type(msg_type), .length(length),
    .data_size(data_size), .cache_type(cache_type), .addr(addr),
    .src_chipid(src_chipid), .data(data), .out_val(out_val), .out_rdy(out_rdy),
    .out_pkg(out_pkg), .stat_req_cnt(stat_req_cnt), .stat_resp_cnt(stat_resp_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic pkt_t rand_pkt();
    pkt_t p;
    p.is_req = 1'($urandom);
    p.last   = 1'($urandom);
    p.sub    = 2'($urandom);
    p.mesi   = 2'($urandom);
    p.mshrid = 8'($urandom);
    p.msg    = 5'($urandom);
    p.len    = 3'($urandom);
    p.dsz    = 3'($urandom);
    p.ct     = 1'($urandom);
    p.addr   = 32'($urandom);
    p.chip   = 6'($urandom);
    for (int i = 0; i < 14; i++) p.data[i*32 +: 32] = 32'($urandom);
    return p;
  endfunction

  // Reference: header is field concatenation; requests keep words 0..4 above two zero slots
  function automatic logic [511:0] exp_pkg(pkt_t p);
    logic [63:0] hdr;
    hdr = {p.chip, p.addr, p.ct, p.dsz, p.len, p.msg, p.mshrid, p.mesi, p.sub, p.last, p.is_req};
    if (p.is_req) return {p.data[319:0], 128'd0, hdr};
    else          return {p.data, hdr};
  endfunction

  task automatic drive(pkt_t p);
    is_request = p.is_req; last_subline = p.last; subline_id = p.sub; mesi = p.mesi;
    mshrid = p.mshrid; msg_type = p.msg; length = p.len; data_size = p.dsz;
    cache_type = p.ct; addr = p.addr; src_chipid = p.chip; data = p.data;
  endtask

  task automatic test_reset;
    tick; tick;
    n_cmp++; if (in_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_in_rdy got %0b want 0", in_rdy); end
    n_cmp++; if (out_val !== 1'b0) begin n_bad++; $display("FAIL rst_out_val got %0b want 0", out_val); end
    n_cmp++; if ({stat_req_cnt, stat_resp_cnt} !== 32'd0) begin n_bad++; $display("FAIL rst_stats got %h/%h want 0/0", stat_req_cnt, stat_resp_cnt); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_rdy !== 1'b0) begin n_bad++; $display("FAIL rel_in_rdy_pre got %0b want 0", in_rdy); end
    tick;
    n_cmp++; if (in_rdy !== 1'b1) begin n_bad++; $display("FAIL rel_in_rdy got %0b want 1", in_rdy); end
    n_cmp++; if (out_val !== 1'b0) begin n_bad++; $display("FAIL rel_out_val got %0b want 0", out_val); end
  endtask

  task automatic test_request;
    pkt_t p;
    logic [511:0] e;
    p = rand_pkt();
    p.is_req = 1'b1; p.addr = 32'h12345678;
    for (int i = 0; i < 7; i++) p.data[i*64 +: 64] = 64'(8'h11 * (i + 1));
    e = exp_pkg(p);
    drive(p); in_val = 1'b1; out_rdy = 1'b0;
    n_cmp++; if (out_val !== 1'b0) begin n_bad++; $display("FAIL req_pre_val got %0b want 0", out_val); end
    tick;
    in_val = 1'b0;
    n_cmp++; if (out_val !== 1'b1) begin n_bad++; $display("FAIL req_latency got %0b want 1", out_val); end
    n_cmp++; if (out_pkg !== e) begin n_bad++; $display("FAIL req_pkg got %h want %h", out_pkg, e); end
    n_cmp++; if (out_pkg[`CEP_ADDR] !== 32'h12345678) begin n_bad++; $display("FAIL req_addr got %h want 12345678", out_pkg[`CEP_ADDR]); end
    n_cmp++; if (out_pkg[`CEP_IS_REQ] !== 1'b1) begin n_bad++; $display("FAIL req_bit got %0b want 1", out_pkg[`CEP_IS_REQ]); end
    n_cmp++; if (out_pkg[3*64 +: 64] !== 64'h11 || out_pkg[7*64 +: 64] !== 64'h55) begin n_bad++; $display("FAIL req_slots got %h/%h want 11/55", out_pkg[3*64 +: 64], out_pkg[7*64 +: 64]); end
    n_cmp++; if (out_pkg[64 +: 128] !== 128'd0) begin n_bad++; $display("FAIL req_gap got %h want 0", out_pkg[64 +: 128]); end
    out_rdy = 1'b1; tick; out_rdy = 1'b0;
    n_cmp++; if (out_val !== 1'b0) begin n_bad++; $display("FAIL req_drain got %0b want 0", out_val); end
  endtask

  task automatic test_response;
    pkt_t p;
    logic [511:0] e;
    p = rand_pkt();
    p.is_req = 1'b0; p.mshrid = 8'd5;
    for (int i = 0; i < 7; i++) p.data[i*64 +: 64] = 64'(8'hA0 + i);
    e = exp_pkg(p);
    drive(p); in_val = 1'b1; out_rdy = 1'b0;
    tick;
    in_val = 1'b0;
    n_cmp++; if (out_pkg[`CEP_MSHRID] !== 8'd5) begin n_bad++; $display("FAIL resp_mshrid got %0d want 5", out_pkg[`CEP_MSHRID]); end
    for (int k = 1; k < 8; k++) begin
      n_cmp++; if (out_pkg[k*64 +: 64] !== 64'(8'hA0 + k - 1)) begin n_bad++; $display("FAIL resp_slot%0d got %h want %h", k, out_pkg[k*64 +: 64], 8'hA0 + k - 1); end
    end
    n_cmp++; if (out_pkg[63:0] !== e[63:0]) begin n_bad++; $display("FAIL resp_hdr got %h want %h", out_pkg[63:0], e[63:0]); end
    out_rdy = 1'b1; tick; out_rdy = 1'b0;
  endtask

  // Fill with out_rdy low, offer one extra, then accept+hand-off at full
  task automatic test_fill_and_full;
    pkt_t q[$];
    pkt_t p;
    out_rdy = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      p = rand_pkt(); drive(p); in_val = 1'b1;
      n_cmp++; if (in_rdy !== (i < DEPTH)) begin n_bad++; $display("FAIL fill_in_rdy%0d got %0b want %0b", i, in_rdy, i < DEPTH); end
      if (i < DEPTH) q.push_back(p);
      tick;
      n_cmp++; if (out_pkg !== exp_pkg(q[0])) begin n_bad++; $display("FAIL fill_head%0d got %h want %h", i, out_pkg, exp_pkg(q[0])); end
    end
    out_rdy = 1'b1;
    n_cmp++; if (in_rdy !== 1'b0) begin n_bad++; $display("FAIL full_both_in_rdy got %0b want 0", in_rdy); end
    tick;
    void'(q.pop_front());
    in_val = 1'b0; out_rdy = 1'b0;
    n_cmp++; if (in_rdy !== 1'b1 || out_val !== 1'b1) begin n_bad++; $display("FAIL full_both_occ got rdy=%0b val=%0b want 1/1", in_rdy, out_val); end
    n_cmp++; if (out_pkg !== exp_pkg(q[0])) begin n_bad++; $display("FAIL full_both_head got %h want %h", out_pkg, exp_pkg(q[0])); end
    out_rdy = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick;
    out_rdy = 1'b0;
    n_cmp++; if (out_val !== 1'b0) begin n_bad++; $display("FAIL full_drain got %0b want 0", out_val); end
  endtask

  // Half-full steady state: one push and one pop every cycle
  task automatic test_back_to_back;
    pkt_t q[$];
    pkt_t p;
    p = rand_pkt(); drive(p); in_val = 1'b1; out_rdy = 1'b0;
    q.push_back(p);
    tick;
    out_rdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      p = rand_pkt(); drive(p);
      n_cmp++; if (in_rdy !== 1'b1 || out_val !== 1'b1) begin n_bad++; $display("FAIL b2b_hs%0d got rdy=%0b val=%0b want 1/1", c, in_rdy, out_val); end
      n_cmp++; if (out_pkg !== exp_pkg(q[0])) begin n_bad++; $display("FAIL b2b_order%0d got %h want %h", c, out_pkg, exp_pkg(q[0])); end
      void'(q.pop_front());
      q.push_back(p);
      tick;
    end
    in_val = 1'b0;
    tick;
    out_rdy = 1'b0;
    n_cmp++; if (out_val !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got %0b want 0", out_val); end
  endtask

  task automatic test_random;
    pkt_t q[$];
    pkt_t p;
    logic acc, hs;
    for (int c = 0; c < 400; c++) begin
      p = rand_pkt(); drive(p);
      in_val  = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 2) != 0);
      acc = in_val && (q.size() < DEPTH);
      hs  = out_rdy && (q.size() != 0);
      n_cmp++; if (in_rdy !== (q.size() < DEPTH)) begin n_bad++; $display("FAIL rnd_in_rdy c%0d got %0b occ %0d", c, in_rdy, q.size()); end
      n_cmp++; if (out_val !== (q.size() != 0)) begin n_bad++; $display("FAIL rnd_out_val c%0d got %0b occ %0d", c, out_val, q.size()); end
      if (q.size() != 0) begin
        n_cmp++; if (out_pkg !== exp_pkg(q[0])) begin n_bad++; $display("FAIL rnd_pkg c%0d got %h want %h", c, out_pkg, exp_pkg(q[0])); end
      end
      if (hs) void'(q.pop_front());
      if (acc) q.push_back(p);
      tick;
    end
    in_val = 1'b0; out_rdy = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick;
    out_rdy = 1'b0;
    n_cmp++; if (out_val !== 1'b0) begin n_bad++; $display("FAIL rnd_drain got %0b want 0", out_val); end
  endtask

  task automatic test_reset_mid;
    pkt_t p;
    out_rdy = 1'b0; in_val = 1'b1;
    for (int i = 0; i < 2; i++) begin p = rand_pkt(); drive(p); tick; end
    in_val = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_val !== 1'b0 || in_rdy !== 1'b0) begin n_bad++; $display("FAIL midrst_async got val=%0b rdy=%0b want 0/0", out_val, in_rdy); end
    tick;
    rst = 1'b0;
    tick;
    n_cmp++; if (out_val !== 1'b0 || in_rdy !== 1'b1) begin n_bad++; $display("FAIL midrst_release got val=%0b rdy=%0b want 0/1", out_val, in_rdy); end
    p = rand_pkt(); drive(p); in_val = 1'b1;
    tick;
    in_val = 1'b0;
    n_cmp++; if (out_val !== 1'b1 || out_pkg !== exp_pkg(p)) begin n_bad++; $display("FAIL midrst_first got val=%0b pkg %h want %h", out_val, out_pkg, exp_pkg(p)); end
    out_rdy = 1'b1; tick; out_rdy = 1'b0;
    n_cmp++; if (out_val !== 1'b0) begin n_bad++; $display("FAIL midrst_drain got %0b want 0", out_val); end
  endtask

  task automatic test_stats;
    pkt_t p;
    int nreq, nresp;
    logic [15:0] exp_req, exp_resp;
    rst = 1'b1; tick; rst = 1'b0; tick;
    nreq = 0; nresp = 0;
    out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      p = rand_pkt(); p.is_req = (i % 2 == 0); drive(p); in_val = 1'b1;
      if (p.is_req) nreq++; else nresp++;
      tick;
    end
    in_val = 1'b0;
    tick; tick;
    out_rdy = 1'b0;
`ifdef CEP_ENCODER_TX_STATS_EN
    exp_req = 16'(nreq); exp_resp = 16'(nresp);
`else
    exp_req = 16'd0; exp_resp = 16'd0;
`endif
    n_cmp++; if (stat_req_cnt !== exp_req) begin n_bad++; $display("FAIL stat_req got %0d want %0d", stat_req_cnt, exp_req); end
    n_cmp++; if (stat_resp_cnt !== exp_resp) begin n_bad++; $display("FAIL stat_resp got %0d want %0d", stat_resp_cnt, exp_resp); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({stat_req_cnt, stat_resp_cnt} !== 32'd0) begin n_bad++; $display("FAIL stat_clear got %0d/%0d want 0/0", stat_req_cnt, stat_resp_cnt); end
    tick; rst = 1'b0; tick;
  endtask

  initial begin
    test_reset();
    test_request();
    test_response();
    test_fill_and_full();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cep_encoder_tx.md
CEP_ENCODER_TX -- requirements
Module: cep_encoder_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of packet entries in the output queue (power of two, >= 2).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_val  input  1  a packet is offered on the field inputs.
REQ-005 SHALL have port in_rdy  output  1  the block accepts the offered packet this cycle.
REQ-006 SHALL have field input ports, each sized by its `CEP_*_WIDTH macro: is_request (1 bit), last_subline, subline_id, mesi, mshrid, msg_type, length, data_size, cache_type, addr, src_chipid.
REQ-007 SHALL have port data  input  7*`CEP_WORD_WIDTH  payload words 0..6, with word 0 in the least-significant bits.
REQ-008 SHALL have port out_val  output  1  out_pkg holds a valid packet.
REQ-009 SHALL have port out_rdy  input  1  the downstream consumer takes out_pkg this cycle.
REQ-010 SHALL have port out_pkg  output  `CEP_DATA_WIDTH  the encoded packet.
REQ-011 SHALL have ports stat_req_cnt and stat_resp_cnt  output  16 each  counts of sent request and response packets (see Configuration).

Function
REQ-012 SHALL place each header field at its bit range in cep_defines.vh: `CEP_IS_REQ, `CEP_LAST_SUBLINE, `CEP_SUBLINE_ID, `CEP_MESI, `CEP_MSHRID, `CEP_MSG_TYPE, `CEP_LENGTH, `CEP_DATA_SIZE, `CEP_CACHE_TYPE, `CEP_ADDR and `CEP_SRC_CHIPID.
REQ-013 SHALL, when is_request=1, place data words 0..4 in package word slots 3..7, where slot k is bits [(k+1)*`CEP_WORD_WIDTH-1 : k*`CEP_WORD_WIDTH], and ignore data words 5..6.
REQ-014 SHALL, when is_request=0, place data words 0..6 in package word slots 1..7.
REQ-015 SHALL drive every out_pkg bit not covered by REQ-012 to REQ-014 to 0.
REQ-016 SHALL accept an input only on the handshake in_val && in_rdy, and SHALL drive in_rdy = (occupancy < DEPTH), with no combinational dependence on out_rdy.
REQ-017 SHALL hand off an output only on the handshake out_val && out_rdy, and SHALL drive out_val = (occupancy != 0).
REQ-018 SHALL drive out_pkg directly from the head queue entry register, with no combinational path from the inputs.
REQ-019 SHALL have a latency of one edge: a packet accepted at edge N appears with out_val=1 after edge N when the queue was empty before it.
REQ-020 SHALL deliver packets strictly in acceptance order.
REQ-021 SHALL, on a simultaneous accept and hand-off at any occupancy, keep occupancy unchanged and apply both operations in the same edge.
REQ-022 SHALL wrap the read and write pointers modulo DEPTH, and SHALL use an occupancy counter of clog2(DEPTH)+1 bits.
REQ-023 SHALL, when full, hold in_rdy=0 even if out_rdy=1 in the same cycle.
REQ-024 SHALL hold out_pkg and out_val stable while out_val=1 and out_rdy=0.

Reset
REQ-025 SHALL, while rst=1, asynchronously clear occupancy, both pointers and both stat counters to 0.
REQ-026 SHALL, while rst=1, force out_val=0 and in_rdy=0.
REQ-027 SHALL discard any queued packets when rst is asserted mid-operation, and SHALL not require the contents of queue entries to be cleared.
REQ-028 SHALL raise in_rdy=1 on the first rising edge after rst deasserts.

Configuration
REQ-029 SHALL, with macro CEP_ENCODER_TX_STATS_EN defined, increment stat_req_cnt on each output hand-off whose packet has its `CEP_IS_REQ bit = 1.
REQ-030 SHALL, with CEP_ENCODER_TX_STATS_EN defined, increment stat_resp_cnt on each output hand-off whose packet has its `CEP_IS_REQ bit = 0.
REQ-031 SHALL saturate both stat counters at 16'hFFFF.
REQ-032 SHALL, with CEP_ENCODER_TX_STATS_EN undefined, keep both stat ports and drive them constant 0, with no counter flops present.

Verification
REQ-033 Request packet, is_request=1, addr=0x12345678, data words 0..6 = 0x11..0x77 -> out_pkg slots 3..7 = 0x11..0x55, words 0x66/0x77 absent, header fields read back at `CEP_* ranges, out_val high one edge after accept.
REQ-034 Response packet, is_request=0, mshrid=5, data words 0..6 = 0xA0..0xA6 -> slots 1..7 = 0xA0..0xA6, slot 0 holds only header bits.
REQ-035 out_rdy=0, push DEPTH+1 packets -> in_rdy drops after DEPTH accepts, and out_pkg holds packet 1 unchanged throughout.
REQ-036 Full queue, in_val=1 and out_rdy=1 in the same cycle -> only the hand-off occurs (in_rdy=0), and occupancy becomes DEPTH-1.
REQ-037 Half-full queue with continuous accept and hand-off for 10 cycles -> occupancy constant, order preserved, pointers wrap correctly.
REQ-038 rst asserted with 2 packets queued -> out_val falls immediately, and after release the first new packet is the one delivered; with CEP_ENCODER_TX_STATS_EN, 3 requests and 2 responses handed off give stat_req_cnt=3 and stat_resp_cnt=2, and the counters reset to 0.
